// File: rtl/reflex_gate_sequencer.sv
// Shared iterative reflex-gate evaluator for NUM_CH round-robin channels.
// Define REFLEX_SEQ_COOLDOWN_EN to add a global reflex refractory counter.
module reflex_gate_sequencer #(
    parameter int NUM_CH          = 4,
    parameter int CONST_WIDTH     = 64,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CONST_WIDTH-1:0] packed_const,
    input  logic                   const_load,
    input  logic [NUM_CH-1:0]      req_valid,
    output logic [NUM_CH-1:0]      req_ready,
    input  logic [NUM_CH*32-1:0]   dt_us,
    input  logic [NUM_CH*16-1:0]   dphi_e4,
    input  logic [NUM_CH*16-1:0]   qsfs_e4,
    input  logic [NUM_CH*16-1:0]   tse_e4,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2:0]             res_ch,
    output logic                   res_trusted,
    output logic                   res_reflex,
    output logic                   res_cfg_err,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, MOD, CMP, OUT} state_t;

    state_t state_q, state_d;

    logic [CONST_WIDTH-1:0] act_const, pend_const;
    logic                   pend_flag;
    logic [2:0]             last_grant, ch_q;
    logic                   dt_neg;
    logic [31:0]            dvd_q;
    logic [32:0]            rem_q;
    logic [4:0]             bit_cnt;
    logic [15:0]            dphi_q, qsfs_q, tse_q;

    logic [27:0] mu;
    logic [15:0] pi_t;
    logic [7:0]  eps_ph, eps_t;

    assign mu     = act_const[59:32];
    assign pi_t   = act_const[31:16];
    assign eps_ph = act_const[15:8];
    assign eps_t  = act_const[7:0];

    logic unused_alpha;
    assign unused_alpha = ^act_const[63:60];

    logic       grant_any, take, hs, cool_ok;
    logic [2:0] grant_idx;

    // Later iterations are closer to last_grant+1, so they win.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req_valid[(int'(last_grant) + i) % NUM_CH]) begin
                grant_any = 1'b1;
                grant_idx = 3'((int'(last_grant) + i) % NUM_CH);
            end
        end
    end

    assign take = rst_n & (state_q == IDLE) & ~pend_flag & grant_any;
    assign hs   = (state_q == OUT) & res_ready;
    assign busy = (state_q != IDLE);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = take && (grant_idx == 3'(i));
        end
    end

    logic [31:0] dt_sel;
    logic [32:0] trial, rem_next;
    logic        timing_ok, phase_ok, fid_ok, trusted;

    assign dt_sel   = dt_us[32*grant_idx +: 32];
    assign trial    = {rem_q[31:0], dvd_q[31]};
    assign rem_next = (trial >= {5'd0, mu}) ? trial - {5'd0, mu} : trial;

    assign timing_ok = ~dt_neg & (mu != '0) & (rem_q < {25'd0, eps_t});
    assign phase_ok  = $signed({dphi_q[15], dphi_q}) < $signed({9'd0, eps_ph});
    assign fid_ok    = (qsfs_q >= pi_t);
    assign trusted   = timing_ok & phase_ok & fid_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = MOD;
            MOD:     if (bit_cnt == 5'd31) state_d = CMP;
            CMP:     state_d = OUT;
            OUT:     if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_const   <= '0;
            pend_const  <= '0;
            pend_flag   <= 1'b0;
            last_grant  <= 3'(NUM_CH - 1);
            ch_q        <= '0;
            dt_neg      <= 1'b0;
            dvd_q       <= '0;
            rem_q       <= '0;
            bit_cnt     <= '0;
            dphi_q      <= '0;
            qsfs_q      <= '0;
            tse_q       <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_trusted <= 1'b0;
            res_reflex  <= 1'b0;
            res_cfg_err <= 1'b0;
        end else begin
            if (state_q == IDLE && pend_flag) begin
                act_const <= pend_const;
                pend_flag <= 1'b0;
            end
            // A load in the apply cycle stays pending for the next one.
            if (const_load) begin
                pend_const <= packed_const;
                pend_flag  <= 1'b1;
            end
            if (take) begin
                ch_q    <= grant_idx;
                dt_neg  <= dt_sel[31];
                dvd_q   <= dt_sel[31] ? (~dt_sel + 32'd1) : dt_sel;
                rem_q   <= '0;
                bit_cnt <= '0;
                dphi_q  <= dphi_e4[16*grant_idx +: 16];
                qsfs_q  <= qsfs_e4[16*grant_idx +: 16];
                tse_q   <= tse_e4[16*grant_idx +: 16];
            end
            if (state_q == MOD) begin
                rem_q   <= rem_next;
                dvd_q   <= {dvd_q[30:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (state_q == CMP) begin
                res_valid   <= 1'b1;
                res_ch      <= ch_q;
                res_trusted <= trusted;
                res_reflex  <= trusted & (tse_q != '0) & cool_ok;
                res_cfg_err <= (mu == '0);
            end
            if (hs) begin
                res_valid  <= 1'b0;
                last_grant <= ch_q;
            end
        end
    end

`ifdef REFLEX_SEQ_COOLDOWN_EN
    logic [31:0] cool_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cool_q <= '0;
        end else if (hs && res_reflex) begin
            cool_q <= 32'(COOLDOWN_CYCLES);
        end else if (cool_q != '0) begin
            cool_q <= cool_q - 32'd1;
        end
    end

    assign cool_ok = (cool_q == '0);
`else
    localparam int unused_cool = COOLDOWN_CYCLES;
    assign cool_ok = 1'b1;
`endif

endmodule
